// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM for the multicycle RV32I core.
// Sequences FETCH/DECODE/execute states and drives every datapath select
// and write enable. It also stalls on mem_ready in FETCH, MEMREAD and MEMWRITE.
//   clk, reset_n        : clock, asynchronous active-low reset
//   op/funct3/funct7b5  : instruction fields from the instruction register
//   zero                : ALU zero flag (branch resolution)
//   mem_ready           : memory finished the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegWrite : datapath controls
//   illegal             : pulse in DECODE on unsupported op/funct3
//   retired             : pulse on the final cycle of each instruction
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal,
  output logic       retired
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  state_t state, state_next;

  logic op_legal, f3_legal, alu_class;
  logic pc_update, branch, ir_en, mw_en, rw_en, ret;
  logic [1:0] alu_op;

  assign op_legal  = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                     (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
  assign alu_class = (op == OP_R) || (op == OP_I);
  assign f3_legal  = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECR, S_EXECI: state_next = S_ALUWB;
      S_ALUWB, S_MEMWB, S_BEQ, S_JAL: state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_en     = 1'b0;
    mw_en     = 1'b0;
    rw_en     = 1'b0;
    ret       = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    unique case (state)
      S_FETCH: begin
        ir_en = mem_ready; pc_update = mem_ready;
        ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWRITE: begin AdrSrc = 1'b1; mw_en = 1'b1; ret = mem_ready; end
      S_MEMWB:    begin ResultSrc = 2'b01; rw_en = 1'b1; ret = 1'b1; end
      S_ALUWB:    begin rw_en = 1'b1; ret = 1'b1; end
      S_EXECR:    begin ALUSrcA = 2'b10; alu_op = 2'b10; end
      S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu_op = 2'b10; end
      S_BEQ:      begin ALUSrcA = 2'b10; alu_op = 2'b01; branch = 1'b1; ret = 1'b1; end
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; ret = 1'b1; end
      default: ;
    endcase

    ALUControl = 3'b000;
    unique case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        unique case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase

    // Enables are gated by reset_n directly so they drop the instant reset asserts.
    PCWrite  = (pc_update | (branch & zero)) & reset_n;
    IRWrite  = ir_en & reset_n;
    MemWrite = mw_en & reset_n;
    RegWrite = rw_en & reset_n;
    retired  = ret & reset_n;
    illegal  = (state == S_DECODE) & reset_n &
               (~op_legal | (alu_class & ~f3_legal));
  end

  always_comb begin
    unique case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised scoreboard bench for multicycle_controller. The driver issues
// whole instructions and pushes the expected per-event summary (cycles since
// the previous event, enable counts, ALU/result/imm selects) into a queue.
// The monitor accumulates the same quantities and checks at each retired/illegal pulse.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, retired;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ill;
    int unsigned cyc, pcw, irw, rw, mw;
    logic [2:0]  alu;   // 3'b111 = no rs1-sourced ALU op seen
    logic [1:0]  res;   // 2'b11 = no register write seen
    logic [1:0]  imm;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] alu_ref(input logic [2:0] f3, input bit sub_ok);
    case (f3)
      3'b000:  return sub_ok ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                       input bit z, input int unsigned fw, input int unsigned mw);
    exp_t e;
    bit f3_ok;
    e = '{ill: 0, cyc: 0, pcw: 1, irw: 1, rw: 0, mw: 0, alu: 3'b111, res: 2'b11, imm: 2'b00};
    f3_ok = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    case (o)
      7'b0000011: begin e.cyc = 5 + fw + mw; e.rw = 1; e.alu = 3'b000; e.res = 2'b01; q.push_back(e); end
      7'b0100011: begin e.cyc = 4 + fw + mw; e.mw = mw + 1; e.alu = 3'b000; e.imm = 2'b01; q.push_back(e); end
      7'b1100011: begin e.cyc = 3 + fw; e.pcw = 1 + z; e.alu = 3'b001; e.imm = 2'b10; q.push_back(e); end
      7'b1101111: begin e.cyc = 3 + fw; e.pcw = 2; e.imm = 2'b11; q.push_back(e); end
      7'b0110011, 7'b0010011: begin
        if (!f3_ok) begin
          // illegal pulse in DECODE, instruction still completes as add
          e.ill = 1; e.cyc = 2 + fw; q.push_back(e);
          e = '{ill: 0, cyc: 2, pcw: 0, irw: 0, rw: 1, mw: 0, alu: 3'b000, res: 2'b00, imm: 2'b00};
        end else begin
          e.cyc = 4 + fw; e.rw = 1; e.res = 2'b00;
          e.alu = alu_ref(f3, (o == 7'b0110011) && f7);
        end
        e.rw = 1; e.res = 2'b00;
        q.push_back(e);
      end
      default: begin e.ill = 1; e.cyc = 2 + fw; q.push_back(e); end
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit mr);
    mem_ready = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                           input bit z, input int unsigned fw, input int unsigned mw);
    model(o, f3, f7, z, fw, mw);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    repeat (fw) cycle(1'b0);
    cycle(1'b1);                       // FETCH completes
    cycle(1'($urandom));               // DECODE
    case (o)
      7'b0000011: begin
        cycle(1'($urandom)); repeat (mw) cycle(1'b0); cycle(1'b1); cycle(1'($urandom));
      end
      7'b0100011: begin
        cycle(1'($urandom)); repeat (mw) cycle(1'b0); cycle(1'b1);
      end
      7'b0110011, 7'b0010011: begin cycle(1'($urandom)); cycle(1'($urandom)); end
      7'b1100011, 7'b1101111: cycle(1'($urandom));
      default: ;
    endcase
  endtask

  // ---------------- monitor ----------------
  int unsigned m_cyc, m_pcw, m_irw, m_rw, m_mw;
  logic [2:0]  m_alu;
  logic [1:0]  m_res;

  task automatic m_clear();
    m_cyc = 0; m_pcw = 0; m_irw = 0; m_rw = 0; m_mw = 0;
    m_alu = 3'b111; m_res = 2'b11;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      chk("rst_enables", {PCWrite, IRWrite, MemWrite, RegWrite, illegal, retired}, 6'b0);
      chk("rst_selects", {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}, 10'b0_10_00_10_000);
      m_clear();
    end else begin
      m_cyc++;
      m_pcw += PCWrite; m_irw += IRWrite; m_rw += RegWrite; m_mw += MemWrite;
      if (ALUSrcA == 2'b10) m_alu = ALUControl;
      if (RegWrite) m_res = ResultSrc;
      if (illegal || retired) begin
        chk("ill_ret_exclusive", illegal & retired, 0);
        if (q.size() == 0) chk("unexpected_event", 1, 0);
        else begin
          e = q.pop_front();
          chk("event_kind",  illegal, e.ill);
          chk("cycles",      m_cyc,   e.cyc);
          chk("pcwrite_cnt", m_pcw,   e.pcw);
          chk("irwrite_cnt", m_irw,   e.irw);
          chk("regwrite_cnt", m_rw,   e.rw);
          chk("memwrite_cnt", m_mw,   e.mw);
          chk("alu_control", m_alu,   e.alu);
          chk("result_src",  m_res,   e.res);
          chk("imm_src",     ImmSrc,  e.imm);
        end
        m_clear();
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [6:0] legal_ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                7'b0010011, 7'b1100011, 7'b1101111};

  initial begin
    logic [6:0] o;
    reset_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0);   // LW zero wait
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 2);   // SW two waits
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);   // SUB
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);   // ADDI
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);   // BEQ taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);   // BEQ not taken
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);   // JAL
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);   // illegal op

    // Reset during MEMREAD with mem_ready low: abort, nothing pushed.
    op = 7'b0000011; funct3 = 3'b010; zero = 1'b1;
    cycle(1'b1); cycle(1'b1); cycle(1'b0);
    chk("in_memread_adrsrc", AdrSrc, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_enables", {PCWrite, IRWrite, MemWrite, RegWrite, illegal, retired}, 6'b0);
    chk("async_rst_fetch", {AdrSrc, ResultSrc, ALUSrcB}, 5'b0_10_10);
    @(posedge clk);
    #1 reset_n = 1'b1;
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1, 1);

    for (int unsigned i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        o = 7'($urandom);
        foreach (legal_ops[k]) if (o == legal_ops[k]) o = 7'b1111111;
      end else o = legal_ops[$urandom_range(0, 5)];
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    mem_ready = 1'b0;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
